// File: rtl/uno_card_pkg.sv
// uno_card_pkg: card slot type, colour codes and geometry defaults
// shared by the card row scheduler and the digit renderers.
package uno_card_pkg;

    typedef struct packed {
        logic       valid;
        logic [3:0] number;
        logic [1:0] color;
    } card_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] BLUE   = 2'b11;

    localparam int DEF_CARD_W = 30;
    localparam int DEF_CARD_H = 50;

    typedef enum logic [1:0] {
        TRK_LEAD,
        TRK_CARD,
        TRK_GAP,
        TRK_DONE
    } trk_state_e;

endpackage

// File: rtl/card_table.sv
// card_table: double-buffered hand table. Game logic writes the shadow
// copy; a requested commit copies it to the active copy at frame_start.
module card_table
    import uno_card_pkg::*;
#(
    parameter int MAX_CARDS = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [3:0]       wr_number,
    input  logic [1:0]       wr_color,
    input  logic             commit,
    input  logic [IDX_W-1:0] rd_idx,
    output card_t            rd_card,
    output logic             commit_pending
);

    card_t shadow [MAX_CARDS];
    card_t active [MAX_CARDS];
    logic  wr_ok;
    logic  swap;

    assign wr_ok = wr_en && (int'(wr_idx) < MAX_CARDS);
    assign swap  = frame_start && commit_pending;

    // Shadow copy: game-side writes, out-of-range slots are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_CARDS; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_ok) begin
            shadow[wr_idx] <= {wr_valid, wr_number, wr_color};
        end
    end

    // Active copy: only ever changes on a frame boundary with a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_CARDS; i++) begin
                active[i] <= '0;
            end
        end else if (swap) begin
            active <= shadow;
        end
    end

    // Pending flag: a swap consumes it; commit sets it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
        end else if (swap) begin
            commit_pending <= 1'b0;
        end else if (commit) begin
            commit_pending <= 1'b1;
        end
    end

    assign rd_card = active[rd_idx];

endmodule

// File: rtl/card_row_scheduler.sv
// card_row_scheduler: walks one row of UNO card slots along the scan
// line. Macro CARD_HIGHLIGHT_EN lifts the selected card by RAISE px.
module card_row_scheduler
    import uno_card_pkg::*;
#(
    parameter int MAX_CARDS = 8,
    parameter int IDX_W     = 3,
    parameter int X0        = 40,
    parameter int Y0        = 400,
    parameter int CARD_W    = DEF_CARD_W,
    parameter int CARD_H    = DEF_CARD_H,
    parameter int GAP       = 8,
    parameter int RAISE     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [9:0]       x_cnt,
    input  logic [9:0]       y_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [3:0]       wr_number,
    input  logic [1:0]       wr_color,
    input  logic             commit,
    input  logic [IDX_W-1:0] sel_idx,
    output logic             commit_pending,
    output logic             card_on,
    output logic [IDX_W-1:0] slot_idx,
    output logic [3:0]       card_number,
    output logic [1:0]       card_color,
    output logic [9:0]       x_pin,
    output logic [9:0]       y_pin
);

    localparam logic [9:0] X0_V   = 10'(X0);
    localparam logic [9:0] STEP_V = 10'(CARD_W + GAP);
    localparam logic [9:0] CW_M1  = 10'(CARD_W - 1);
    localparam logic [9:0] CH_M1  = 10'(CARD_H - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_CARDS - 1);

    trk_state_e       state;
    logic [IDX_W-1:0] slot;
    logic [9:0]       pin;
    logic [9:0]       y_top;
    logic             y_ok;
    logic             hit;
    card_t            cur;

    card_table #(
        .MAX_CARDS (MAX_CARDS),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start    (frame_start),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_valid       (wr_valid),
        .wr_number      (wr_number),
        .wr_color       (wr_color),
        .commit         (commit),
        .rd_idx         (slot),
        .rd_card        (cur),
        .commit_pending (commit_pending)
    );

`ifdef CARD_HIGHLIGHT_EN
    logic [IDX_W-1:0] sel_q;

    // Selection is latched per frame so a card never tears mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else if (frame_start) begin
            sel_q <= sel_idx;
        end
    end

    assign y_top = (slot == sel_q) ? 10'(Y0 - RAISE) : 10'(Y0);
`else
    logic unused_sel;

    assign unused_sel = ^sel_idx;
    assign y_top      = 10'(Y0);
`endif

    assign y_ok = (y_cnt >= y_top) && (y_cnt <= y_top + CH_M1);
    assign hit  = (state == TRK_CARD) && y_ok && cur.valid;

    // Slot tracker: pin/slot advance by adds only, restarted at x==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TRK_DONE;
            slot  <= '0;
            pin   <= '0;
        end else if (x_cnt == 10'd0) begin
            state <= TRK_LEAD;
            slot  <= '0;
            pin   <= X0_V;
        end else begin
            case (state)
                TRK_LEAD: begin
                    if (x_cnt == X0_V - 10'd1) begin
                        state <= TRK_CARD;
                    end
                end
                TRK_CARD: begin
                    if (x_cnt == pin + CW_M1) begin
                        if (slot == LAST) begin
                            state <= TRK_DONE;
                        end else begin
                            state <= TRK_GAP;
                            pin   <= pin + STEP_V;
                            slot  <= slot + IDX_W'(1);
                        end
                    end
                end
                TRK_GAP: begin
                    if (x_cnt == pin - 10'd1) begin
                        state <= TRK_CARD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Renderer outputs: one cycle behind the scan, zeroed off-card.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            card_on     <= 1'b0;
            slot_idx    <= '0;
            card_number <= '0;
            card_color  <= '0;
            x_pin       <= '0;
            y_pin       <= '0;
        end else begin
            card_on     <= hit;
            slot_idx    <= slot;
            card_number <= hit ? cur.number : 4'd0;
            card_color  <= hit ? cur.color : 2'd0;
            x_pin       <= hit ? pin : 10'd0;
            y_pin       <= hit ? y_top : 10'd0;
        end
    end

endmodule

// File: tb/tb_card_row_scheduler.sv
// tb_card_row_scheduler: directed and random scans checked against a
// slot-arithmetic model of the card row and its double-buffered table.
module tb_card_row_scheduler;

    localparam int MAXC  = 8;
    localparam int X0    = 40;
    localparam int Y0    = 400;
    localparam int CW    = 30;
    localparam int CH    = 50;
    localparam int STEP  = 38;
    localparam int RAISE = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] x_cnt = '0;
    logic [9:0] y_cnt = '0;
    logic       wr_en = 1'b0;
    logic       wr_en6 = 1'b0;
    logic [2:0] wr_idx = '0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_number = '0;
    logic [1:0] wr_color = '0;
    logic       commit = 1'b0;
    logic [2:0] sel_idx = '0;

    logic       commit_pending, card_on;
    logic [2:0] slot_idx;
    logic [3:0] card_number;
    logic [1:0] card_color;
    logic [9:0] x_pin, y_pin;

    logic       commit_pending6, card_on6;
    logic [2:0] slot_idx6;
    logic [3:0] card_number6;
    logic [1:0] card_color6;
    logic [9:0] x_pin6, y_pin6;

    card_row_scheduler u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .x_cnt(x_cnt), .y_cnt(y_cnt),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
        .wr_number(wr_number), .wr_color(wr_color),
        .commit(commit), .sel_idx(sel_idx),
        .commit_pending(commit_pending), .card_on(card_on),
        .slot_idx(slot_idx), .card_number(card_number),
        .card_color(card_color), .x_pin(x_pin), .y_pin(y_pin)
    );

    card_row_scheduler #(.MAX_CARDS(6), .IDX_W(3)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .x_cnt(x_cnt), .y_cnt(y_cnt),
        .wr_en(wr_en6), .wr_idx(wr_idx), .wr_valid(wr_valid),
        .wr_number(wr_number), .wr_color(wr_color),
        .commit(commit), .sel_idx(sel_idx),
        .commit_pending(commit_pending6), .card_on(card_on6),
        .slot_idx(slot_idx6), .card_number(card_number6),
        .card_color(card_color6), .x_pin(x_pin6), .y_pin(y_pin6)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit rnd_on = 0;

    int sh_v [MAXC], sh_n [MAXC], sh_c [MAXC];
    int ac_v [MAXC], ac_n [MAXC], ac_c [MAXC];
    int pend_m, line_ok, sel_m;
    int e_on, e_slot, e_num, e_col, e_xp, e_yp, chk_slot;

    int obs_on [640], obs_num [640], obs_col [640];
    int obs_slot [640], obs_xp [640], obs_yp [640];

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: expected outputs for the pixel sampled at this edge.
    always @(posedge clk) begin : cmp
        int xs, ys, k, ytop, fs, cm, we, wi;
        xs = int'(x_cnt);
        ys = int'(y_cnt);
        fs = int'(frame_start);
        cm = int'(commit);
        we = int'(wr_en);
        wi = int'(wr_idx);
        e_on = 0; e_num = 0; e_col = 0; e_xp = 0; e_yp = 0;
        e_slot = 0; chk_slot = 1;
        if (!rst_n) begin
            for (int i = 0; i < MAXC; i++) begin
                sh_v[i] = 0; sh_n[i] = 0; sh_c[i] = 0;
                ac_v[i] = 0; ac_n[i] = 0; ac_c[i] = 0;
            end
            pend_m = 0; line_ok = 0; sel_m = 0;
        end else begin
            if (line_ok && xs == 0) chk_slot = 0;
            if (line_ok && xs >= X0 + CW) begin
                e_slot = (xs - X0 - CW) / STEP + 1;
                if (e_slot > MAXC - 1) e_slot = MAXC - 1;
            end
            if (line_ok && xs >= X0) begin
                k = (xs - X0) / STEP;
                if (k < MAXC && (xs - X0) % STEP < CW) begin
                    ytop = Y0;
`ifdef CARD_HIGHLIGHT_EN
                    if (k == sel_m) ytop = Y0 - RAISE;
`endif
                    if (ys >= ytop && ys < ytop + CH && ac_v[k] != 0) begin
                        e_on = 1;
                        e_num = ac_n[k];
                        e_col = ac_c[k];
                        e_xp = X0 + k * STEP;
                        e_yp = ytop;
                    end
                end
            end
            if (xs == 0) line_ok = 1;
            if (fs != 0 && pend_m != 0) begin
                for (int i = 0; i < MAXC; i++) begin
                    ac_v[i] = sh_v[i]; ac_n[i] = sh_n[i]; ac_c[i] = sh_c[i];
                end
                pend_m = 0;
            end else if (cm != 0) begin
                pend_m = 1;
            end
            if (fs != 0) sel_m = int'(sel_idx);
            if (we != 0 && wi < MAXC) begin
                sh_v[wi] = int'(wr_valid);
                sh_n[wi] = int'(wr_number);
                sh_c[wi] = int'(wr_color);
            end
        end
        #1;
        chk("card_on", int'(card_on), e_on);
        if (chk_slot != 0) chk("slot_idx", int'(slot_idx), e_slot);
        chk("card_number", int'(card_number), e_num);
        chk("card_color", int'(card_color), e_col);
        chk("x_pin", int'(x_pin), e_xp);
        chk("y_pin", int'(y_pin), e_yp);
        chk("commit_pending", int'(commit_pending), pend_m);
        chk("d6_pending", int'(commit_pending6), pend_m);
        chk("d6_outs", int'({card_on6, card_number6, card_color6,
                             x_pin6, y_pin6}), 0);
        chk("d6_slot_range", int'(slot_idx6 <= 3'd5), 1);
        if (xs < 640) begin
            obs_on[xs] = int'(card_on);
            obs_num[xs] = int'(card_number);
            obs_col[xs] = int'(card_color);
            obs_slot[xs] = int'(slot_idx);
            obs_xp[xs] = int'(x_pin);
            obs_yp[xs] = int'(y_pin);
        end
    end

    task automatic drive(int x, int y);
        @(negedge clk);
        x_cnt = 10'(x);
        y_cnt = 10'(y);
        wr_en = 1'b0;
        wr_en6 = 1'b0;
        commit = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle();
        drive(639, 0);
    endtask

    task automatic wr(int idx, int v, int n, int c);
        idle();
        wr_en = 1'b1;
        wr_idx = 3'(idx);
        wr_valid = 1'(v);
        wr_number = 4'(n);
        wr_color = 2'(c);
    endtask

    task automatic wr6(int idx);
        idle();
        wr_en6 = 1'b1;
        wr_idx = 3'(idx);
        wr_valid = 1'b1;
        wr_number = 4'd8;
        wr_color = 2'd3;
    endtask

    task automatic do_commit();
        idle();
        commit = 1'b1;
    endtask

    task automatic frame(int with_commit);
        idle();
        frame_start = 1'b1;
        commit = 1'(with_commit);
    endtask

    task automatic scan_line(int y, int stop);
        for (int x = 0; x <= stop; x++) begin
            drive(x, y);
            if (rnd_on) begin
                if ($urandom_range(31) == 0) begin
                    wr_en = 1'b1;
                    wr_idx = 3'($urandom_range(7));
                    wr_valid = 1'($urandom_range(3) != 0);
                    wr_number = 4'($urandom_range(9));
                    wr_color = 2'($urandom_range(3));
                end
                if ($urandom_range(299) == 0) commit = 1'b1;
            end
        end
    endtask

    initial begin
        int ys [6];
        repeat (3) @(negedge clk);
        chk("rst_card_on", int'(card_on), 0);
        chk("rst_pending", int'(commit_pending), 0);
        chk("rst_x_pin", int'(x_pin), 0);
        idle();
        rst_n = 1'b1;

        wr(0, 1, 2, 1);
        do_commit();
        frame(0);
        scan_line(400, 349);
        idle();
        chk("lit_on_39", obs_on[39], 0);
        chk("lit_on_40", obs_on[40], 1);
        chk("lit_num_40", obs_num[40], 2);
        chk("lit_col_40", obs_col[40], 1);
        chk("lit_xpin_40", obs_xp[40], 40);
        chk("lit_ypin_40", obs_yp[40], 400);
        chk("lit_on_69", obs_on[69], 1);
        chk("lit_on_70", obs_on[70], 0);
        chk("lit_on_77", obs_on[77], 0);
        chk("lit_slot_78", obs_slot[78], 1);

        wr(7, 1, 9, 3);
        frame(0);
        scan_line(400, 349);
        idle();
        chk("lit_s7_nocommit", obs_on[306], 0);
        do_commit();
        frame(0);
        scan_line(400, 349);
        idle();
        chk("lit_s7_on_306", obs_on[306], 1);
        chk("lit_s7_on_335", obs_on[335], 1);
        chk("lit_s7_off_336", obs_on[336], 0);
        chk("lit_s7_xpin", obs_xp[306], 306);
        scan_line(449, 349);
        idle();
        chk("lit_s7_y449", obs_on[320], 1);
        scan_line(450, 349);
        idle();
        chk("lit_s7_y450", obs_on[320], 0);

        wr(0, 1, 5, 1);
        do_commit();
        scan_line(420, 349);
        idle();
        chk("lit_midframe_old", obs_num[50], 2);
        frame(0);
        scan_line(400, 349);
        idle();
        chk("lit_nextframe_new", obs_num[50], 5);

        wr(1, 1, 3, 2);
        wr6(7);
        wr6(6);
        frame(1);
        idle();
        chk("lit_defer_pend", int'(commit_pending), 1);
        scan_line(400, 349);
        idle();
        chk("lit_defer_off", obs_on[80], 0);
        frame(0);
        scan_line(400, 349);
        idle();
        chk("lit_defer_on", obs_on[80], 1);
        chk("lit_defer_num", obs_num[80], 3);
        chk("lit_defer_col", obs_col[80], 2);
        chk("lit_defer_xpin", obs_xp[80], 78);

        do_commit();
        scan_line(410, 50);
        chk("lit_pre_rst_on", int'(card_on), 1);
        chk("lit_pre_rst_pend", int'(commit_pending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_rst_card_on", int'(card_on), 0);
        chk("lit_rst_pend", int'(commit_pending), 0);
        chk("lit_rst_outs", int'({card_number, card_color,
                                  x_pin, y_pin, slot_idx}), 0);
        repeat (2) idle();
        idle();
        rst_n = 1'b1;
        scan_line(400, 349);
        idle();
        chk("lit_rst_empty", obs_on[50], 0);

        rnd_on = 1;
        for (int f = 0; f < 12; f++) begin
            idle();
            frame_start = 1'b1;
            commit = 1'($urandom_range(3) == 0);
            sel_idx = 3'($urandom_range(7));
            ys[0] = 399;
            ys[1] = 400;
            ys[2] = 401;
            ys[3] = int'($urandom_range(402, 448));
            ys[4] = 449;
            ys[5] = 450;
            for (int l = 0; l < 6; l++) begin
                scan_line(ys[l], 349);
                idle();
            end
        end
        rnd_on = 0;
        repeat (2) idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
